// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: RV32I instruction fetch with req/gnt/rvalid imem port, credit-limited prefetch and redirect flush
// Ports:
//   clk_i, resetn_i                  clock, asynchronous active-low reset
//   stall_i, redirect_i              decode stall, branch/jump restart
//   redirect_pc_i                    restart target (low two bits ignored)
//   imem_req_o/addr_o/gnt_i          request channel, address is the fetch PC
//   imem_rvalid_i/rdata_i            in-order response channel
//   instr_valid_o/instr_o/instr_pc_o buffered instruction to decode (NOP when empty)
//   proto_err_o                      sticky: response seen with nothing outstanding
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        proto_err_o
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] fetch_pc;
  logic [OW-1:0] outst, outst_n, discard;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr, rd, pq_wr, pq_rd;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] pc_q [FIFO_DEPTH];
  logic [31:0] pq [FIFO_DEPTH];
  logic fire, rv_ok, push, pop, perr;
  logic unused_pc_lo;
  assign unused_pc_lo = ^redirect_pc_i[1:0];
  // Credits count both in-flight requests and buffered words so every response has a slot.
  assign imem_req_o = resetn_i && (outst < OW'(MAX_OUTST)) &&
                      ((SW'(outst) + SW'(cnt)) < SW'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc;
  assign fire = imem_req_o && imem_gnt_i;
  assign rv_ok = imem_rvalid_i && (outst != '0);
  assign push = rv_ok && !redirect_i && (discard == '0);
  assign pop = instr_valid_o && !stall_i && !redirect_i;
  assign outst_n = outst + OW'(fire) - OW'(rv_ok);
  assign instr_valid_o = cnt != '0;
  assign instr_o = instr_valid_o ? data_q[rd] : NOP;
  assign instr_pc_o = instr_valid_o ? pc_q[rd] : 32'h0;
  assign proto_err_o = perr;
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      fetch_pc <= RESET_PC;
      outst <= '0;
      discard <= '0;
      cnt <= '0;
      wr <= '0;
      rd <= '0;
      pq_wr <= '0;
      pq_rd <= '0;
      perr <= 1'b0;
    end else begin
      outst <= outst_n;
      perr <= perr | (imem_rvalid_i && (outst == '0));
      pq_wr <= pq_wr + PW'(fire);
      pq_rd <= pq_rd + PW'(rv_ok);
      if (redirect_i) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        discard <= outst_n;
        cnt <= '0;
        rd <= wr;
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (rv_ok && (discard != '0)) discard <= discard - OW'(1);
        wr <= wr + PW'(push);
        rd <= rd + PW'(pop);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
  // Pending-PC queue tags each response with the address it was fetched from.
  always_ff @(posedge clk_i) begin
    if (fire) pq[pq_wr] <= fetch_pc;
    if (push) begin
      data_q[wr] <= imem_rdata_i;
      pc_q[wr] <= pq[pq_rd];
    end
  end
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: directed table, corner sequences and random traffic against a queue-based fetch model
module tb_rv32i_fetch_unit;
  localparam int DEPTH = 2;
  localparam int MAXO = 2;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, resetn = 1, stall = 0, redir = 0, gnt = 0, rvalid = 0;
  logic [31:0] rpc = 0, rdata = 0;
  logic imem_req_o, instr_valid_o, proto_err_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o;
  always #5 clk = ~clk;
  rv32i_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .clk_i(clk), .resetn_i(resetn), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .proto_err_o(proto_err_o)
  );
  typedef struct {logic [31:0] addr; int t; bit stale;} req_t;
  typedef struct {
    bit st; bit rd; logic [31:0] tgt; bit g; bit r;
    bit e_req; logic [31:0] e_addr; bit e_val; logic [31:0] e_pc;
  } vec_t;
  req_t mq[$];
  logic [31:0] fq[$];
  logic [31:0] exp_fetch;
  bit exp_perr;
  int cyc, nchk, nerr;
  vec_t tbl [21];
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic apply(input bit st, input bit rd, input logic [31:0] tgt, input bit g, input bit r, input bit sp);
    bit er, ev, drv;
    req_t e;
    er = (mq.size() < MAXO) && (mq.size() + fq.size() < DEPTH);
    ev = fq.size() > 0;
    chk("req", imem_req_o, er);
    chk("addr", imem_addr_o, exp_fetch);
    chk("valid", instr_valid_o, ev);
    chk("pc", instr_pc_o, ev ? fq[0] : 32'h0);
    chk("instr", instr_o, ev ? f(fq[0]) : NOP);
    chk("perr", proto_err_o, exp_perr);
    drv = sp || (r && mq.size() > 0 && mq[0].t < cyc);
    stall = st; redir = rd; rpc = tgt; gnt = g; rvalid = drv;
    rdata = (drv && !sp) ? f(mq[0].addr) : $urandom;
    if (ev && !st && !rd) void'(fq.pop_front());
    if (sp) exp_perr = 1;
    else if (drv) begin
      e = mq.pop_front();
      if (!e.stale && !rd) fq.push_back(e.addr);
    end
    if (er && g) begin
      mq.push_back('{exp_fetch, cyc, 1'b0});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rd) begin
      fq.delete();
      foreach (mq[i]) mq[i].stale = 1;
      exp_fetch = {tgt[31:2], 2'b00};
    end
    cyc++;
  endtask
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt, input bit g, input bit r, input bit sp);
    @(negedge clk);
    apply(st, rd, tgt, g, r, sp);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_req"}, imem_req_o, 0);
    chk({tag, "_addr"}, imem_addr_o, RPC);
    chk({tag, "_valid"}, instr_valid_o, 0);
    chk({tag, "_instr"}, instr_o, NOP);
    chk({tag, "_pc"}, instr_pc_o, 0);
    chk({tag, "_perr"}, proto_err_o, 0);
  endtask
  initial begin
    tbl = '{
      '{0,0,0,1,1, 1,32'h000,0,0},     '{0,0,0,1,1, 1,32'h004,0,0},
      '{0,0,0,1,1, 0,32'h008,1,32'h000}, '{0,0,0,1,1, 1,32'h008,1,32'h004},
      '{0,0,0,1,1, 1,32'h00C,0,0},     '{0,0,0,1,1, 0,32'h010,1,32'h008},
      '{0,0,0,1,0, 1,32'h010,1,32'h00C}, '{0,0,0,1,0, 1,32'h014,0,0},
      '{0,1,32'h100,1,0, 0,32'h018,0,0}, '{0,0,0,1,1, 0,32'h100,0,0},
      '{0,0,0,1,1, 1,32'h100,0,0},     '{0,0,0,0,1, 1,32'h104,0,0},
      '{1,0,0,0,0, 1,32'h104,1,32'h100}, '{1,0,0,0,0, 1,32'h104,1,32'h100},
      '{1,0,0,0,0, 1,32'h104,1,32'h100}, '{0,0,0,1,0, 1,32'h104,1,32'h100},
      '{0,1,32'h203,1,1, 1,32'h108,0,0}, '{0,0,0,1,1, 1,32'h200,0,0},
      '{0,0,0,0,1, 1,32'h204,0,0},     '{0,0,0,0,0, 1,32'h204,1,32'h200},
      '{0,0,0,0,0, 1,32'h204,0,0}
    };
    #1 resetn = 0;
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst");
    exp_fetch = RPC;
    resetn = 1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), imem_req_o, tbl[i].e_req);
      chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), instr_valid_o, tbl[i].e_val);
      chk($sformatf("tbl%0d_pc", i), instr_pc_o, tbl[i].e_pc);
      apply(tbl[i].st, tbl[i].rd, tbl[i].tgt, tbl[i].g, tbl[i].r, 0);
    end
    for (int k = 0; k < 5; k++) step(1, 0, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    chk("stall_req", imem_req_o, 0);
    chk("stall_pc", instr_pc_o, 32'h204);
    chk("stall_instr", instr_o, f(32'h204));
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] t;
      t = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      step($urandom % 4 == 0, $urandom % 20 == 0, t, $urandom % 4 != 0, $urandom % 3 != 0, 0);
    end
    for (int k = 0; k < 200 && (mq.size() > 0 || fq.size() > 0); k++) step(0, 0, 0, 0, 1, 0);
    nchk++;
    if (mq.size() > 0 || fq.size() > 0) begin
      nerr++;
      $display("FAIL drain: %0d outstanding %0d buffered, required 0 0", mq.size(), fq.size());
    end
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0);
    chk("perr_sticky", proto_err_o, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #2 resetn = 0;
    stall = 0; redir = 0; gnt = 0; rvalid = 0;
    #1 reset_checks("midrst");
    mq.delete();
    fq.delete();
    exp_fetch = RPC;
    exp_perr = 0;
    @(negedge clk);
    resetn = 1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("late_perr", proto_err_o, 1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
